// File: rtl/sdram_port_arbiter.sv
// Requester side of the SDRAM controller handshake: picks write/read bursts and owns the ring-buffer pointers.
// Optional define SDRAM_RD_GATE_EN adds an occupancy counter so reads never overtake writes.
module sdram_port_arbiter #(
  parameter int                 ADDR_W     = 24,
  parameter int                 WR_BURST   = 256,
  parameter int                 RD_BURST   = 256,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [ADDR_W-1:0]  END_ADDR   = 24'h100000,
  parameter int                 RDF_DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic [9:0]        wrf_usedw,
  input  logic [9:0]        rdf_usedw,
  input  logic              rd_valid,
  input  logic              wr_load,
  input  logic              rd_load,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [9:0]        sdram_wr_burst,
  output logic [9:0]        sdram_rd_burst,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;

  localparam logic [ADDR_W:0] WR_STEP = (ADDR_W+1)'(WR_BURST);
  localparam logic [ADDR_W:0] RD_STEP = (ADDR_W+1)'(RD_BURST);
  localparam logic [ADDR_W:0] END_EXT = {1'b0, END_ADDR};

  state_t            state;
  logic              tok_wr;
  logic              wr_load_pend, rd_load_pend;
  logic              wr_ack_q, rd_ack_q;
  logic              wr_cond, rd_cond, wr_ok, rd_ok;
  logic              wr_active, rd_active;
  logic              wr_done, rd_done;
  logic [ADDR_W:0]   wr_sum, rd_sum;
  logic [ADDR_W-1:0] wr_next, rd_next;

  assign sdram_wr_burst = 10'(WR_BURST);
  assign sdram_rd_burst = 10'(RD_BURST);

  assign wr_cond = {1'b0, wrf_usedw} >= 11'(WR_BURST);
  assign rd_cond = rd_valid && (({1'b0, rdf_usedw} + 11'(RD_BURST)) <= 11'(RDF_DEPTH));

  assign wr_active = (state == WR_REQ) || (state == WR_BUSY);
  assign rd_active = (state == RD_REQ) || (state == RD_BUSY);
  // burst ends on the falling edge of ack
  assign wr_done   = (state == WR_BUSY) && wr_ack_q && !sdram_wr_ack;
  assign rd_done   = (state == RD_BUSY) && rd_ack_q && !sdram_rd_ack;

  assign wr_sum  = {1'b0, sdram_wr_addr} + WR_STEP;
  assign rd_sum  = {1'b0, sdram_rd_addr} + RD_STEP;
  assign wr_next = (wr_sum >= END_EXT) ? START_ADDR : wr_sum[ADDR_W-1:0];
  assign rd_next = (rd_sum >= END_EXT) ? START_ADDR : rd_sum[ADDR_W-1:0];

`ifdef SDRAM_RD_GATE_EN
  localparam logic [24:0] REGION = 25'(END_ADDR) - 25'(START_ADDR);
  logic [24:0] occ;

  always_ff @(posedge clk) begin
    if (!rst_n || wr_load || rd_load) occ <= '0;
    else if (wr_done)                 occ <= occ + 25'(WR_BURST);
    else if (rd_done)                 occ <= occ - 25'(RD_BURST);
  end

  assign wr_ok = wr_cond && ((occ + 25'(WR_BURST)) <= REGION);
  assign rd_ok = rd_cond && (occ >= 25'(RD_BURST));
`else
  assign wr_ok = wr_cond;
  assign rd_ok = rd_cond;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= START_ADDR;
      sdram_rd_addr <= START_ADDR;
      busy          <= 1'b0;
      tok_wr        <= 1'b1;
      wr_load_pend  <= 1'b0;
      rd_load_pend  <= 1'b0;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
    end else begin
      wr_ack_q <= sdram_wr_ack;
      rd_ack_q <= sdram_rd_ack;

      // a load aimed at a direction mid-transaction is deferred to its completion
      if (wr_active) begin
        if (wr_load) wr_load_pend <= 1'b1;
      end else if (wr_load) begin
        sdram_wr_addr <= START_ADDR;
      end
      if (rd_active) begin
        if (rd_load) rd_load_pend <= 1'b1;
      end else if (rd_load) begin
        sdram_rd_addr <= START_ADDR;
      end

      case (state)
        IDLE: begin
          if (sdram_init_done) begin
            if (wr_ok && (!rd_ok || tok_wr)) begin
              state        <= WR_REQ;
              sdram_wr_req <= 1'b1;
              busy         <= 1'b1;
              if (rd_ok) tok_wr <= 1'b0;
            end else if (rd_ok) begin
              state        <= RD_REQ;
              sdram_rd_req <= 1'b1;
              busy         <= 1'b1;
              if (wr_ok) tok_wr <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (sdram_wr_ack) begin
            sdram_wr_req <= 1'b0;
            state        <= WR_BUSY;
          end
        end
        WR_BUSY: begin
          if (wr_done) begin
            state         <= IDLE;
            busy          <= 1'b0;
            wr_load_pend  <= 1'b0;
            sdram_wr_addr <= (wr_load || wr_load_pend) ? START_ADDR : wr_next;
          end
        end
        RD_REQ: begin
          if (sdram_rd_ack) begin
            sdram_rd_req <= 1'b0;
            state        <= RD_BUSY;
          end
        end
        RD_BUSY: begin
          if (rd_done) begin
            state         <= IDLE;
            busy          <= 1'b0;
            rd_load_pend  <= 1'b0;
            sdram_rd_addr <= (rd_load || rd_load_pend) ? START_ADDR : rd_next;
          end
        end
        default: begin
          state        <= IDLE;
          sdram_wr_req <= 1'b0;
          sdram_rd_req <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected (direction, address) pairs are queued when
// stimulus is applied and compared when the DUT raises a request.
module tb_sdram_port_arbiter;

  localparam logic [23:0] S = 24'h000100;
  localparam logic [23:0] E = 24'h000900;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [9:0]  wrf_usedw, rdf_usedw;
  logic        rd_valid, wr_load, rd_load;
  logic        wr_req, rd_req, wr_ack, rd_ack;
  logic [23:0] wr_addr, rd_addr;
  logic [9:0]  wr_burst, rd_burst;
  logic        busy;

  typedef struct packed {logic is_wr; logic [23:0] addr;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W(24), .WR_BURST(256), .RD_BURST(256),
    .START_ADDR(S), .END_ADDR(E), .RDF_DEPTH(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init_done),
    .wrf_usedw(wrf_usedw), .rdf_usedw(rdf_usedw), .rd_valid(rd_valid),
    .wr_load(wr_load), .rd_load(rd_load),
    .sdram_wr_req(wr_req), .sdram_rd_req(rd_req),
    .sdram_wr_ack(wr_ack), .sdram_rd_ack(rd_ack),
    .sdram_wr_addr(wr_addr), .sdram_rd_addr(rd_addr),
    .sdram_wr_burst(wr_burst), .sdram_rd_burst(rd_burst),
    .busy(busy)
  );

  task automatic wait_req(output logic ok);
    int n = 0;
    while (!(wr_req || rd_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = wr_req || rd_req;
  endtask

  // controller model: waits for a request, acks one cycle later, holds ack for ack_len cycles
  task automatic serve(input int ack_len, output logic ok, output logic is_wr, output logic [23:0] addr);
    wait_req(ok);
    is_wr = wr_req;
    addr  = wr_req ? wr_addr : rd_addr;
    if (!ok) return;
    @(negedge clk);
    if (is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
    repeat (ack_len) @(negedge clk);
    wr_ack = 1'b0;
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_done = 1'b0; wrf_usedw = '0; rdf_usedw = '0;
    rd_valid = 1'b0; wr_load = 1'b0; rd_load = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_req !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL reset_req: wr=%b rd=%b want 0 0", wr_req, rd_req); end
    checks++; if (wr_addr !== S || rd_addr !== S) begin errors++; $display("FAIL reset_addr: wr=%h rd=%h want %h", wr_addr, rd_addr, S); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wr_burst !== 10'd256 || rd_burst !== 10'd256) begin errors++; $display("FAIL burst_len: wr=%0d rd=%0d want 256", wr_burst, rd_burst); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_write();
    exp_q.push_back('{1'b1, S});
    init_done = 1'b1;
    wrf_usedw = 10'd300;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (wr_req !== e.is_wr || rd_req !== 1'b0 || wr_addr !== e.addr) begin errors++; $display("FAIL first_req: wr=%b rd=%b addr=%h want wr=1 addr=%h", wr_req, rd_req, wr_addr, e.addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b want 1", busy); end
    wr_ack = 1'b1;
    @(negedge clk);
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", wr_req); end
    repeat (255) @(negedge clk);
    checks++; if (wr_addr !== S || busy !== 1'b1) begin errors++; $display("FAIL mid_burst: addr=%h busy=%b want %h 1", wr_addr, busy, S); end
    wr_ack = 1'b0;
    wrf_usedw = '0;
    @(negedge clk);
    checks++; if (wr_addr !== S + 24'd256 || busy !== 1'b0 || wr_req !== 1'b0) begin errors++; $display("FAIL first_done: addr=%h busy=%b req=%b want %h 0 0", wr_addr, busy, wr_req, S + 24'd256); end
  endtask

  task automatic test_token();
    logic ok, is_wr;
    logic [23:0] addr;
    exp_q.push_back('{1'b1, S + 24'd256});
    exp_q.push_back('{1'b0, S});
    exp_q.push_back('{1'b1, S + 24'd512});
    exp_q.push_back('{1'b0, S + 24'd256});
    wrf_usedw = 10'd300; rd_valid = 1'b1; rdf_usedw = '0;
    for (int i = 0; i < 4; i++) begin
      serve(8, ok, is_wr, addr);
      if (i == 3) begin wrf_usedw = '0; rd_valid = 1'b0; end
      e = exp_q.pop_front();
      checks++; if (!ok || is_wr !== e.is_wr || addr !== e.addr) begin errors++; $display("FAIL token[%0d]: ok=%b wr=%b addr=%h want wr=%b addr=%h", i, ok, is_wr, addr, e.is_wr, e.addr); end
    end
    @(negedge clk);
    checks++; if (wr_addr !== S + 24'd768 || rd_addr !== S + 24'd512) begin errors++; $display("FAIL token_addr: wr=%h rd=%h want %h %h", wr_addr, rd_addr, S + 24'd768, S + 24'd512); end
  endtask

  task automatic test_conditions();
    logic ok, is_wr, seen;
    logic [23:0] addr;
    seen = 1'b0;
    wrf_usedw = 10'd255; rd_valid = 1'b1; rdf_usedw = 10'd769;
    repeat (6) begin @(negedge clk); if (wr_req || rd_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL below_threshold: req seen=%b want 0", seen); end
    exp_q.push_back('{1'b0, S + 24'd512});
    rdf_usedw = 10'd768;
    serve(4, ok, is_wr, addr);
    rd_valid = 1'b0; rdf_usedw = '0;
    e = exp_q.pop_front();
    checks++; if (!ok || is_wr !== e.is_wr || addr !== e.addr) begin errors++; $display("FAIL rd_edge: ok=%b wr=%b addr=%h want wr=%b addr=%h", ok, is_wr, addr, e.is_wr, e.addr); end
    exp_q.push_back('{1'b1, S + 24'd768});
    wrf_usedw = 10'd256;
    serve(4, ok, is_wr, addr);
    wrf_usedw = '0;
    e = exp_q.pop_front();
    checks++; if (!ok || is_wr !== e.is_wr || addr !== e.addr) begin errors++; $display("FAIL wr_edge: ok=%b wr=%b addr=%h want wr=%b addr=%h", ok, is_wr, addr, e.is_wr, e.addr); end
    @(negedge clk);
    checks++; if (wr_addr !== S + 24'd1024 || rd_addr !== S + 24'd768) begin errors++; $display("FAIL cond_addr: wr=%h rd=%h want %h %h", wr_addr, rd_addr, S + 24'd1024, S + 24'd768); end
  endtask

  task automatic test_wrap();
    logic ok, is_wr;
    logic [23:0] addr;
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, S + 24'd1024 + 24'(i * 256)});
    wrf_usedw = 10'd300;
    for (int i = 0; i < 4; i++) begin
      serve(3, ok, is_wr, addr);
      if (i == 3) wrf_usedw = '0;
      e = exp_q.pop_front();
      checks++; if (!ok || is_wr !== e.is_wr || addr !== e.addr) begin errors++; $display("FAIL wrap[%0d]: ok=%b wr=%b addr=%h want wr=%b addr=%h", i, ok, is_wr, addr, e.is_wr, e.addr); end
    end
    @(negedge clk);
    checks++; if (wr_addr !== S) begin errors++; $display("FAIL wrap_addr: got %h want %h", wr_addr, S); end
  endtask

  task automatic test_load();
    logic ok, is_wr;
    logic [23:0] addr;
    exp_q.push_back('{1'b0, S + 24'd768});
    rd_valid = 1'b1;
    wait_req(ok);
    rd_valid = 1'b0;
    e = exp_q.pop_front();
    checks++; if (!ok || rd_req !== 1'b1 || rd_addr !== e.addr) begin errors++; $display("FAIL load_rd_req: ok=%b rd=%b addr=%h want 1 %h", ok, rd_req, rd_addr, e.addr); end
    @(negedge clk);
    rd_ack = 1'b1;
    repeat (3) @(negedge clk);
    rd_load = 1'b1;
    @(negedge clk);
    rd_load = 1'b0;
    checks++; if (rd_addr !== S + 24'd768) begin errors++; $display("FAIL load_deferred: got %h want %h", rd_addr, S + 24'd768); end
    repeat (3) @(negedge clk);
    rd_ack = 1'b0;
    @(negedge clk);
    checks++; if (rd_addr !== S) begin errors++; $display("FAIL rd_load_busy: got %h want %h", rd_addr, S); end
    exp_q.push_back('{1'b0, S});
    rd_valid = 1'b1;
    serve(3, ok, is_wr, addr);
    rd_valid = 1'b0;
    e = exp_q.pop_front();
    checks++; if (!ok || is_wr !== e.is_wr || addr !== e.addr) begin errors++; $display("FAIL rd_after_load: ok=%b wr=%b addr=%h want wr=%b addr=%h", ok, is_wr, addr, e.is_wr, e.addr); end
    @(negedge clk);
    checks++; if (rd_addr !== S + 24'd256) begin errors++; $display("FAIL pend_clear: got %h want %h", rd_addr, S + 24'd256); end
    // load arriving on the completion edge
    exp_q.push_back('{1'b1, S});
    wrf_usedw = 10'd300;
    serve(3, ok, is_wr, addr);
    wrf_usedw = '0;
    wr_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    e = exp_q.pop_front();
    checks++; if (!ok || is_wr !== e.is_wr || addr !== e.addr) begin errors++; $display("FAIL wr_pre_load: ok=%b wr=%b addr=%h want wr=%b addr=%h", ok, is_wr, addr, e.is_wr, e.addr); end
    checks++; if (wr_addr !== S) begin errors++; $display("FAIL load_wins: got %h want %h", wr_addr, S); end
    exp_q.push_back('{1'b1, S});
    wrf_usedw = 10'd300;
    serve(3, ok, is_wr, addr);
    wrf_usedw = '0;
    e = exp_q.pop_front();
    @(negedge clk);
    checks++; if (!ok || addr !== e.addr || wr_addr !== S + 24'd256) begin errors++; $display("FAIL wr_after_load: ok=%b addr=%h ptr=%h want %h %h", ok, addr, wr_addr, e.addr, S + 24'd256); end
    wr_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    checks++; if (wr_addr !== S || busy !== 1'b0) begin errors++; $display("FAIL wr_load_idle: addr=%h busy=%b want %h 0", wr_addr, busy, S); end
    wr_ack = 1'b1; rd_ack = 1'b1;
    repeat (3) @(negedge clk);
    wr_ack = 1'b0; rd_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wr_addr !== S || rd_addr !== S + 24'd256 || busy !== 1'b0 || wr_req !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL stray_ack: wr=%h rd=%h busy=%b want %h %h 0", wr_addr, rd_addr, busy, S, S + 24'd256); end
  endtask

  task automatic test_init_done();
    logic ok, is_wr, seen;
    logic [23:0] addr;
    int n;
    seen = 1'b0;
    init_done = 1'b0; wrf_usedw = 10'd300; rd_valid = 1'b1; rdf_usedw = '0;
    repeat (100) begin @(negedge clk); if (wr_req || rd_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL init_block: req seen=%b want 0", seen); end
    exp_q.push_back('{1'b1, S});
    init_done = 1'b1;
    n = 0;
    while (!(wr_req || rd_req) && n < 10) begin @(negedge clk); n++; end
    checks++; if (n > 2 || n == 0) begin errors++; $display("FAIL init_latency: got %0d cycles want 1..2", n); end
    init_done = 1'b0;
    serve(5, ok, is_wr, addr);
    e = exp_q.pop_front();
    checks++; if (!ok || is_wr !== e.is_wr || addr !== e.addr) begin errors++; $display("FAIL init_burst: ok=%b wr=%b addr=%h want wr=%b addr=%h", ok, is_wr, addr, e.is_wr, e.addr); end
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (wr_req || rd_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0 || wr_addr !== S + 24'd256 || busy !== 1'b0) begin errors++; $display("FAIL init_drop: seen=%b addr=%h busy=%b want 0 %h 0", seen, wr_addr, busy, S + 24'd256); end
    wrf_usedw = '0; rd_valid = 1'b0;
    init_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    logic ok;
    exp_q.push_back('{1'b1, S + 24'd256});
    wrf_usedw = 10'd300;
    wait_req(ok);
    e = exp_q.pop_front();
    checks++; if (!ok || wr_req !== 1'b1 || wr_addr !== e.addr) begin errors++; $display("FAIL rst_burst_req: ok=%b wr=%b addr=%h want 1 %h", ok, wr_req, wr_addr, e.addr); end
    @(negedge clk);
    wr_ack = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (wr_req !== 1'b0 || rd_req !== 1'b0 || wr_addr !== S || rd_addr !== S || busy !== 1'b0) begin errors++; $display("FAIL rst_mid: wr=%b rd=%b wa=%h ra=%h busy=%b want 0 0 %h %h 0", wr_req, rd_req, wr_addr, rd_addr, busy, S, S); end
    wr_ack = 1'b0; wrf_usedw = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (wr_addr !== S || busy !== 1'b0) begin errors++; $display("FAIL rst_after: addr=%h busy=%b want %h 0", wr_addr, busy, S); end
  endtask

`ifdef SDRAM_RD_GATE_EN
  task automatic test_rd_gate();
    logic ok, is_wr, seen;
    logic [23:0] addr;
    test_reset();
    init_done = 1'b1; rd_valid = 1'b1; rdf_usedw = '0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (rd_req) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL gate_block: rd_req seen=%b want 0", seen); end
    exp_q.push_back('{1'b1, S});
    exp_q.push_back('{1'b0, S});
    wrf_usedw = 10'd300;
    serve(4, ok, is_wr, addr);
    wrf_usedw = '0;
    e = exp_q.pop_front();
    checks++; if (!ok || is_wr !== e.is_wr || addr !== e.addr) begin errors++; $display("FAIL gate_wr: ok=%b wr=%b addr=%h want wr=%b addr=%h", ok, is_wr, addr, e.is_wr, e.addr); end
    serve(4, ok, is_wr, addr);
    rd_valid = 1'b0;
    e = exp_q.pop_front();
    checks++; if (!ok || is_wr !== e.is_wr || addr !== e.addr) begin errors++; $display("FAIL gate_rd: ok=%b wr=%b addr=%h want wr=%b addr=%h", ok, is_wr, addr, e.is_wr, e.addr); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_first_write();
    test_token();
    test_conditions();
    test_wrap();
    test_load();
    test_init_done();
    test_reset_mid_burst();
`ifdef SDRAM_RD_GATE_EN
    test_rd_gate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
